// File: rtl/unidade_controle_jogo_pkg.sv
// rtl/unidade_controle_jogo_pkg.sv - state encodings, timeout default and Moore output decode for the game control unit
package unidade_controle_jogo_pkg;

   // state encodings; values are what the 7-seg debug display shows
   localparam logic [3:0] C_INICIAL     = 4'h0;
   localparam logic [3:0] C_PREPARACAO  = 4'h1;
   localparam logic [3:0] C_ESPERA      = 4'h2;
   localparam logic [3:0] C_REGISTRA    = 4'h4;
   localparam logic [3:0] C_COMPARACAO  = 4'h5;
   localparam logic [3:0] C_PROXIMO     = 4'h6;
   localparam logic [3:0] C_FIM_ACERTOU = 4'hA;
   localparam logic [3:0] C_FIM_TIMEOUT = 4'hD;
   localparam logic [3:0] C_FIM_ERROU   = 4'hE;

   // cycles allowed in espera before giving up (timeout build only)
   localparam int C_TIMEOUT_CYCLES = 5000;

   typedef enum logic [3:0] {
      ST_INICIAL     = C_INICIAL,
      ST_PREPARACAO  = C_PREPARACAO,
      ST_ESPERA      = C_ESPERA,
      ST_REGISTRA    = C_REGISTRA,
      ST_COMPARACAO  = C_COMPARACAO,
      ST_PROXIMO     = C_PROXIMO,
      ST_FIM_ACERTOU = C_FIM_ACERTOU,
      ST_FIM_TIMEOUT = C_FIM_TIMEOUT,
      ST_FIM_ERROU   = C_FIM_ERROU
   } estado_t;

   typedef struct packed {
      logic zerac;
      logic contac;
      logic zerar;
      logic registrar;
      logic pronto;
      logic acertou;
      logic errou;
   } saidas_t;

   // Moore decode: every output is a function of the state alone
   function automatic saidas_t decodifica(input estado_t e);
      saidas_t s;
      s           = '0;
      s.zerac     = (e == ST_PREPARACAO);
      s.zerar     = (e == ST_PREPARACAO);
      s.registrar = (e == ST_REGISTRA);
      s.contac    = (e == ST_PROXIMO);
      s.pronto    = (e == ST_FIM_ACERTOU) || (e == ST_FIM_ERROU) || (e == ST_FIM_TIMEOUT);
      s.acertou   = (e == ST_FIM_ACERTOU);
      s.errou     = (e == ST_FIM_ERROU) || (e == ST_FIM_TIMEOUT);
      return s;
   endfunction

endpackage

// File: rtl/unidade_controle_jogo_edge_detector.sv
// rtl/unidade_controle_jogo_edge_detector.sv - rising-edge detector giving a one-cycle pulse per low-to-high transition
module unidade_controle_jogo_edge_detector (
   input  logic clock,
   input  logic clr,
   input  logic sinal,
   output logic pulso
);

   logic r_hist;

   // remember last cycle's level so a held input yields a single pulse
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         r_hist <= 1'b0;
      end else begin
         r_hist <= sinal;
      end
   end

   assign pulso = sinal & ~r_hist;

endmodule

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - round sequencer FSM for the 4-play game; macro TIMEOUT_EN adds an espera timeout
module unidade_controle_jogo
   import unidade_controle_jogo_pkg::*;
`ifdef TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
)
`endif
(
   input  logic       clock,
   input  logic       clr,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic [3:0] db_estado
);

   estado_t r_estado;
   estado_t w_prox;
   saidas_t w_saidas;
   logic    w_jogada_pulse;

   unidade_controle_jogo_edge_detector u_borda_jogada (
      .clock (clock),
      .clr   (clr),
      .sinal (jogada),
      .pulso (w_jogada_pulse)
   );

`ifdef TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] r_cnt_espera;
   logic             w_estourou;

   assign w_estourou = (r_cnt_espera == CNT_W'(TIMEOUT_CYCLES - 1));

   // count consecutive cycles spent waiting for a play; any other state restarts the count
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         r_cnt_espera <= '0;
      end else if (r_estado == ST_ESPERA && w_prox == ST_ESPERA) begin
         r_cnt_espera <= r_cnt_espera + 1'b1;
      end else begin
         r_cnt_espera <= '0;
      end
   end
`endif

   // next-state rules; mismatch outranks the last-address flag in comparacao
   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         ST_INICIAL:     if (iniciar) w_prox = ST_PREPARACAO;
         ST_PREPARACAO:  w_prox = ST_ESPERA;
         ST_ESPERA: begin
            if (w_jogada_pulse) begin
               w_prox = ST_REGISTRA;
            end
`ifdef TIMEOUT_EN
            else if (w_estourou) begin
               w_prox = ST_FIM_TIMEOUT;
            end
`endif
         end
         ST_REGISTRA:    w_prox = ST_COMPARACAO;
         ST_COMPARACAO: begin
            if (!igual) begin
               w_prox = ST_FIM_ERROU;
            end else if (fimC) begin
               w_prox = ST_FIM_ACERTOU;
            end else begin
               w_prox = ST_PROXIMO;
            end
         end
         ST_PROXIMO:     w_prox = ST_ESPERA;
         ST_FIM_ACERTOU: if (iniciar) w_prox = ST_PREPARACAO;
         ST_FIM_ERROU:   if (iniciar) w_prox = ST_PREPARACAO;
`ifdef TIMEOUT_EN
         ST_FIM_TIMEOUT: if (iniciar) w_prox = ST_PREPARACAO;
`endif
         default:        w_prox = ST_INICIAL;
      endcase
   end

   assign w_saidas = decodifica(w_prox);

   // state and outputs register together so outputs always match the displayed state
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         r_estado  <= ST_INICIAL;
         zeraC     <= 1'b0;
         contaC    <= 1'b0;
         zeraR     <= 1'b0;
         registraR <= 1'b0;
         pronto    <= 1'b0;
         acertou   <= 1'b0;
         errou     <= 1'b0;
      end else begin
         r_estado  <= w_prox;
         zeraC     <= w_saidas.zerac;
         contaC    <= w_saidas.contac;
         zeraR     <= w_saidas.zerar;
         registraR <= w_saidas.registrar;
         pronto    <= w_saidas.pronto;
         acertou   <= w_saidas.acertou;
         errou     <= w_saidas.errou;
      end
   end

   assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb/tb_unidade_controle_jogo.sv - self-checking bench for unidade_controle_jogo against a round-level model
module tb_unidade_controle_jogo;

   logic       clock = 1'b0;
   logic       clr = 1'b0;
   logic       iniciar = 1'b0;
   logic       jogada = 1'b0;
   logic       igual = 1'b1;
   logic       fimC = 1'b0;
   logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
   logic [3:0] db_estado;

   always #5 clock = ~clock;

`ifdef TIMEOUT_EN
   localparam int  TO_CYC = 8;
   localparam bit  TO_ON  = 1'b1;
   unidade_controle_jogo #(.TIMEOUT_CYCLES(TO_CYC)) u_dut (
      .clock(clock), .clr(clr), .iniciar(iniciar), .jogada(jogada), .igual(igual), .fimC(fimC),
      .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
      .pronto(pronto), .acertou(acertou), .errou(errou), .db_estado(db_estado)
   );
`else
   localparam int  TO_CYC = 8;
   localparam bit  TO_ON  = 1'b0;
   unidade_controle_jogo u_dut (
      .clock(clock), .clr(clr), .iniciar(iniciar), .jogada(jogada), .igual(igual), .fimC(fimC),
      .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
      .pronto(pronto), .acertou(acertou), .errou(errou), .db_estado(db_estado)
   );
`endif

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // round-level model: where in the round we are, derived from the game rules
   typedef enum int {M_IDLE, M_PREP, M_WAIT, M_LOAD, M_CMP, M_ADV, M_OK, M_ERR, M_TO} mode_t;
   mode_t m_mode = M_IDLE;
   logic  m_jq = 1'b0;
   int    m_wait = 0;
   logic  m_pulse;
   assign m_pulse = jogada & ~m_jq;

   function automatic logic [3:0] disp(input mode_t m);
      case (m)
         M_IDLE: return 4'h0;
         M_PREP: return 4'h1;
         M_WAIT: return 4'h2;
         M_LOAD: return 4'h4;
         M_CMP:  return 4'h5;
         M_ADV:  return 4'h6;
         M_OK:   return 4'hA;
         M_ERR:  return 4'hE;
         default: return 4'hD;
      endcase
   endfunction

   always @(posedge clock or negedge clr) begin
      if (!clr) begin
         m_mode <= M_IDLE;
         m_jq   <= 1'b0;
         m_wait <= 0;
      end else begin
         m_jq <= jogada;
         case (m_mode)
            M_IDLE, M_OK, M_ERR, M_TO: if (iniciar) m_mode <= M_PREP;
            M_PREP: begin m_mode <= M_WAIT; m_wait <= 0; end
            M_WAIT: begin
               if (m_pulse) m_mode <= M_LOAD;
               else if (TO_ON && m_wait == TO_CYC - 1) m_mode <= M_TO;
               else m_wait <= m_wait + 1;
            end
            M_LOAD: m_mode <= M_CMP;
            M_CMP:  m_mode <= !igual ? M_ERR : (fimC ? M_OK : M_ADV);
            M_ADV:  begin m_mode <= M_WAIT; m_wait <= 0; end
            default: m_mode <= M_IDLE;
         endcase
      end
   end

   int   cyc = 0;
   int   n_conta = 0;
   int   n_reg = 0;
   int   rise_cyc = -1;
   logic prev_pronto = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // per-cycle comparison against the model, plus pulse bookkeeping from observed outputs
   always @(negedge clock) begin
      if (clr) begin
         chk("db_estado", db_estado, disp(m_mode));
         chk("zeraC", zeraC, m_mode == M_PREP);
         chk("zeraR", zeraR, m_mode == M_PREP);
         chk("registraR", registraR, m_mode == M_LOAD);
         chk("contaC", contaC, m_mode == M_ADV);
         chk("pronto", pronto, m_mode == M_OK || m_mode == M_ERR || m_mode == M_TO);
         chk("acertou", acertou, m_mode == M_OK);
         chk("errou", errou, m_mode == M_ERR || m_mode == M_TO);
         if (contaC) n_conta <= n_conta + 1;
         if (registraR) n_reg <= n_reg + 1;
         if (pronto && !prev_pronto) rise_cyc <= cyc;
         prev_pronto <= pronto;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   int c0;

   task automatic start_round();
      iniciar = 1'b1;
      step(1);
      c0 = cyc;
      iniciar = 1'b0;
      step(1);
   endtask

   task automatic play(input logic ig, input logic fc);
      jogada = 1'b1;
      igual  = ig;
      fimC   = fc;
      step(1);
      jogada = 1'b0;
      step(2);
      fimC  = 1'b0;
      igual = 1'b1;
      step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int bc, br;

   initial begin
      // reset held for two cycles
      clr = 1'b0;
      step(2);
      chk("reset_state", db_estado, 4'h0);
      chk("reset_outs", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou}, 7'b0);
      clr = 1'b1;
      step(10);
      chk("idle_state", db_estado, 4'h0);

      // full successful round
      bc = n_conta; br = n_reg;
      start_round();
      play(1'b1, 1'b0);
      play(1'b1, 1'b0);
      play(1'b1, 1'b0);
      play(1'b1, 1'b1);
      chk("ok_state", db_estado, 4'hA);
      chk("ok_flags", {pronto, acertou, errou}, 3'b110);
      chk("ok_conta_pulses", n_conta - bc, 3);
      chk("ok_reg_pulses", n_reg - br, 4);
      chk("ok_latency_edges", rise_cyc - c0 + 1, 17);

      // restart from the success state
      iniciar = 1'b1;
      step(1);
      chk("restart_state", db_estado, 4'h1);
      chk("restart_clears", {zeraC, zeraR}, 2'b11);
      iniciar = 1'b0;
      step(1);

      // mismatch on the second play
      bc = n_conta;
      play(1'b1, 1'b0);
      play(1'b0, 1'b0);
      chk("err2_state", db_estado, 4'hE);
      chk("err2_flags", {pronto, acertou, errou}, 3'b101);
      chk("err2_conta_pulses", n_conta - bc, 1);

      // mismatch together with last-address flag on the fourth play
      bc = n_conta;
      start_round();
      play(1'b1, 1'b0);
      play(1'b1, 1'b0);
      play(1'b1, 1'b0);
      play(1'b0, 1'b1);
      chk("err4_state", db_estado, 4'hE);
      chk("err4_conta_pulses", n_conta - bc, 3);

      // held button, with iniciar raised mid-round (must be ignored)
      start_round();
      bc = n_conta; br = n_reg;
      iniciar = 1'b1;
      jogada  = 1'b1;
      igual   = 1'b1;
      fimC    = 1'b0;
      step(20);
      jogada  = 1'b0;
      iniciar = 1'b0;
      step(2);
      chk("held_state", db_estado, 4'h2);
      chk("held_reg_pulses", n_reg - br, 1);
      chk("held_conta_pulses", n_conta - bc, 1);

      // asynchronous reset while registering
      jogada = 1'b1;
      step(1);
      chk("pre_reset_state", db_estado, 4'h4);
      chk("pre_reset_reg", registraR, 1'b1);
      clr = 1'b0;
      #1;
      chk("async_reset_state", db_estado, 4'h0);
      chk("async_reset_reg", registraR, 1'b0);
      jogada = 1'b0;
      step(1);
      clr = 1'b1;
      step(2);
      chk("after_reset_state", db_estado, 4'h0);

`ifdef TIMEOUT_EN
      // no play for TIMEOUT_CYCLES cycles in espera
      start_round();
      step(TO_CYC - 1);
      chk("to_not_yet", db_estado, 4'h2);
      step(1);
      chk("to_state", db_estado, 4'hD);
      chk("to_flags", {pronto, acertou, errou}, 3'b101);

      // a play in the last allowed cycle wins over the timeout
      start_round();
      step(TO_CYC - 1);
      jogada = 1'b1;
      step(1);
      chk("to_pulse_wins", db_estado, 4'h4);
      jogada = 1'b0;
      step(3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Moore FSM that sequences the 2-bit address counter (74163-style, 4 positions) plus a play register and comparator.
- Runs one round of 4 plays: clear counter/register, wait for a play, register it, compare, advance address, finish on last address or on mismatch.
- Sits beside the datapath in the experiment top level; top level wires counter clr = ~zeraC, ent = enp = contaC, ld = 1.

Parameters:
TIMEOUT_CYCLES, 5000, cycles allowed in espera before timeout (used only with TIMEOUT_EN)

Ports:
clock  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
iniciar  input  1  start/restart request, level, sampled on clock
jogada  input  1  raw play button level; rising edge detected internally
igual  input  1  comparator result, registered play == memory word
fimC  input  1  counter rco (address == 3 with enable)
zeraC  output  1  clear address counter (active-high here)
contaC  output  1  increment address counter
zeraR  output  1  clear play register
registraR  output  1  load play register
pronto  output  1  round finished
acertou  output  1  round finished, all plays matched
errou  output  1  round finished, mismatch (or timeout)
db_estado  output  4  current state encoding, for 7-seg debug

Behaviour:
- States/encodings: inicial 0x0, preparacao 0x1, espera 0x2, registra 0x4, comparacao 0x5, proximo 0x6, fim_acertou 0xA, fim_errou 0xE, fim_timeout 0xD (only with TIMEOUT_EN).
- Reset (clr=0, asynchronous): state=inicial; all outputs 0; db_estado=0x0; edge-detector history register=0.
- All outputs are Moore, decoded from state only. A one-hot output is 1 only in the listed state:
  - zeraC, zeraR: preparacao
  - registraR: registra
  - contaC: proximo
  - pronto: fim_acertou, fim_errou, fim_timeout
  - acertou: fim_acertou
  - errou: fim_errou, fim_timeout
- Transitions (evaluated each rising edge):
  - inicial: iniciar=1 -> preparacao; else stay.
  - preparacao -> espera unconditionally (1 cycle).
  - espera: jogada_pulse=1 -> registra; else stay.
  - registra -> comparacao (1 cycle; register loads on this edge).
  - comparacao: igual=0 -> fim_errou; else fimC=1 -> fim_acertou; else proximo. Mismatch has priority over fimC.
  - proximo -> espera (counter increments on this edge).
  - fim_acertou, fim_errou, fim_timeout: iniciar=1 -> preparacao; else stay.
- Any unused encoding -> inicial on next edge.
- Edge detection:
  - jogada_pulse = jogada & ~jogada_q, combinational.
  - jogada_q is a register of jogada.
  - Held button gives exactly one pulse; a pulse occurring outside espera is ignored, not queued.
- Latency: jogada first sampled high while in espera -> registra at the next edge -> comparacao one edge later.
- Best-case round (4 matches): iniciar edge to pronto = 1 + 4*(1 wait min + 3) edges.
- iniciar held high in a final state restarts immediately; iniciar is ignored in all mid-round states.
- Asynchronous reset mid-round returns to inicial within the same cycle. Counter and register contents are not touched by this block on reset.

Optional Feature:
Macro TIMEOUT_EN.
- Defined:
  - Internal timeout counter sized for TIMEOUT_CYCLES, cleared in every state except espera, incrementing in espera.
  - When it reaches TIMEOUT_CYCLES-1 with no jogada_pulse -> fim_timeout (pronto=1, errou=1, db_estado=0xD).
  - jogada_pulse in that same cycle wins -> registra.
- Undefined: no timer logic; espera waits indefinitely; 0xD is treated as an unused encoding.

Decomposition:
- Shared package/include: state encodings (localparam 4-bit constants), TIMEOUT_CYCLES default.
- Sub-module edge_detector (clock, clr, sinal, pulso): async active-low reset, rising-edge one-cycle pulse. Reused for iniciar debouncing elsewhere.

Test Plan:
- Reset: clr=0 for 2 cycles -> state 0x0, all outputs 0; release, iniciar=0 for 10 cycles -> stays 0x0.
- Full success: iniciar pulse; 4 plays with igual=1, fimC=1 only on the 4th comparacao -> contaC pulses exactly 3 times, then 0xA with pronto=acertou=1, errou=0.
- Early mismatch: play 2 with igual=0, fimC=0 -> 0xE, pronto=errou=1, contaC pulsed once; mismatch+fimC on play 4 also -> 0xE.
- Held button: jogada high for 20 cycles in espera -> exactly one registraR pulse, FSM back in espera (0x2) after proximo.
- Restart and mid-round reset: in 0xA assert iniciar -> 0x1 next edge with zeraC=zeraR=1; assert clr=0 while in 0x4 -> 0x0 immediately, registraR=0.
- TIMEOUT_EN with TIMEOUT_CYCLES=8: no jogada for 8 cycles in espera -> 0xD, errou=1, pronto=1; pulse in the 8th cycle -> 0x4 instead.
